fifo_stream_reader: RTL and testbench

- Read-side consumer for the team's 8-bit synchronous FIFO.
- Drains the FIFO through its rd_en/empty/registered-data interface. The FIFO's read data is valid one cycle after rd_en.
- Presents the words on a valid/ready stream with a 2-entry output buffer, so throughput is one word per cycle with no bubbles or loss under backpressure.
- Tags the last word of each fixed-length burst and keeps a running transfer count for status.

---
 rtl/fifo_stream_reader.sv | 116 +++++++++++
 tb/tb_fifo_stream_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Read-side consumer for the 8-bit synchronous FIFO. It pulls words through
// the FIFO's rd_en/empty/registered-data interface and presents them on a
// valid/ready stream. A 2-entry circular buffer absorbs the one-cycle read
// latency, so the stream runs at one word per cycle under backpressure with
// no loss. Every BURST_LEN-th transfer is tagged with m_last, and a wrapping
// count of accepted transfers is kept for status.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (synchronous release upstream)
//   enable      allows new FIFO reads while high
//   fifo_empty  FIFO empty flag, valid in the current cycle
//   fifo_data   FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read strobe (combinational)
//   m_valid     stream word available
//   m_ready     downstream accepts the word
//   m_data      stream word
//   m_last      final word of the current burst
//   xfer_count  total accepted transfers, wraps
//   busy        read in flight or buffer non-empty

module fifo_stream_reader #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] xfer_count,
  output logic             busy
);

  localparam logic [7:0]       LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [DW-1:0] entry0;
  logic [DW-1:0] entry1;
  logic          head;
  logic          tail;
  logic [1:0]    occ;
  logic          inflight;
  logic [7:0]    beat_cnt;

  logic          xfer;
  logic [2:0]    pending;
  logic [DW-1:0] head_data;

  assign head_data = head ? entry1 : entry0;

  // A word returning from the FIFO is offered on the stream in the same cycle
  // it arrives when the buffer is empty. This keeps the read-to-valid latency
  // at one cycle. If it is not taken, it is written to the tail entry anyway,
  // so the next cycle shows the same word from the buffer head.
  assign m_valid = (occ != 2'd0) || inflight;
  assign m_data  = ((occ == 2'd0) && inflight) ? fifo_data : head_data;
  assign xfer    = m_valid && m_ready;

  // Words that will be owned by the reader after this edge. xfer implies at
  // least one word is owned, so the subtraction cannot underflow.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};

  // Only issue a read if its returning word has a guaranteed buffer slot.
  assign fifo_rd_en = rst_n && enable && !fifo_empty && (pending < 3'd2);

  assign m_last = m_valid && (beat_cnt == LAST_BEAT);
  assign busy   = inflight || (occ != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0     <= '0;
      entry1     <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      beat_cnt   <= 8'd0;
      xfer_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= pending[1:0];

      // Writing the tail and advancing the head in the same cycle is fine
      // even when the buffer is empty and the word was taken straight away.
      // Both pointers move together and occ stays at zero.
      if (inflight) begin
        if (tail) begin
          entry1 <= fifo_data;
        end else begin
          entry0 <= fifo_data;
        end
        tail <= ~tail;
      end

      if (xfer) begin
        head       <= ~head;
        xfer_count <= xfer_count + CNT_ONE;
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= 8'd0;
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//
// Directed and randomized bench for fifo_stream_reader. A behavioural FIFO
// with registered read data feeds the DUT. The reference model tracks:
//   - the ordered queue of words that should leave the stream;
//   - the number of words the reader has taken from the FIFO but not yet
//     handed downstream;
//   - the number of accepted transfers.
// Expected valid, busy, read strobe, last tag and counts all come from those
// three quantities.

module tb_fifo_stream_reader;

  localparam int DW        = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_data = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic [CNT_W-1:0] xfer_count;
  logic             busy;

  fifo_stream_reader #(
    .DW(DW),
    .BURST_LEN(BURST_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .xfer_count(xfer_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural source FIFO: read data is registered, valid after rd_en.
  logic [DW-1:0] fmem [0:2047];
  int fwr = 0;
  int frd = 0;
  assign fifo_empty = (fwr == frd);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fmem[frd];
      frd <= frd + 1;
    end
  end

  // Reference model state.
  logic [DW-1:0] exp_q [$];
  int outst = 0;
  int xfers = 0;
  int n_asserts = 0;
  int fails = 0;

  // Per-test history for directed timing checks.
  logic          h_rd    [64];
  logic          h_valid [64];
  logic          h_xfer  [64];
  logic          h_busy  [64];
  logic [DW-1:0] h_data  [64];
  logic [1:0]    h_occ   [64];
  int            lc;
  int            xidx;
  logic [31:0]   lastmask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fmem[fwr] = w;
    fwr++;
    exp_q.push_back(w);
  endtask

  task automatic start_test();
    lc = 0;
    xidx = 0;
    lastmask = '0;
  endtask

  // One clock cycle: entered 1 time unit after a rising edge.
  task automatic cyc(input logic en, input logic rdy);
    logic ev, ex, erd, elast;
    enable  = en;
    m_ready = rdy;
    #1;
    ev    = (outst != 0);
    ex    = ev && rdy;
    erd   = en && !fifo_empty && ((outst - (ex ? 1 : 0)) < 2);
    elast = ev && ((xfers % BURST_LEN) == (BURST_LEN - 1));
    chk("m_valid", 32'(m_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(ev));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(erd));
    chk("xfer_count", 32'(xfer_count), 32'(xfers[CNT_W-1:0]));
    chk("m_last", 32'(m_last), 32'(elast));
    chk("occ_le_2", 32'(dut.occ <= 2'd2), 32'd1);
    chk("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
    if (ev) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
      else chk("m_data", 32'(m_data), 32'(exp_q[0]));
    end
    if (lc < 64) begin
      h_rd[lc]    = fifo_rd_en;
      h_valid[lc] = m_valid;
      h_xfer[lc]  = m_valid && m_ready;
      h_busy[lc]  = busy;
      h_data[lc]  = m_data;
      h_occ[lc]   = dut.occ;
    end
    lc++;
    if (ex) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      xfers++;
      xidx++;
      if (m_last && xidx < 32) lastmask[xidx] = 1'b1;
    end
    outst = outst + (erd ? 1 : 0) - (ex ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release after an edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    outst = 0;
    xfers = 0;
    exp_q.delete();
    for (int i = frd; i < fwr; i++) exp_q.push_back(fmem[i]);
  endtask

  initial begin
    int guard;
    logic en_r, rdy_r;

    // Directed 1: basic latency. The FIFO is non-empty and enabled during
    // reset, so the read strobe must still be held low.
    enable  = 1'b1;
    m_ready = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    #2;
    apply_reset();
    start_test();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    chk("d1_rd_pattern", 32'({h_rd[0], h_rd[1], h_rd[2], h_rd[3], h_rd[4]}), 32'b11100);
    chk("d1_valid_pattern", 32'({h_valid[0], h_valid[1], h_valid[2], h_valid[3], h_valid[4]}), 32'b01110);
    chk("d1_data_c1", 32'(h_data[1]), 32'h11);
    chk("d1_data_c2", 32'(h_data[2]), 32'h22);
    chk("d1_data_c3", 32'(h_data[3]), 32'h33);
    chk("d1_busy_c4", 32'(h_busy[4]), 32'd0);
    chk("d1_xfer_count", 32'(xfer_count), 32'd3);

    // Directed 2: backpressure with eight words queued.
    start_test();
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
    chk("d2_rd_stall", 32'({h_rd[0], h_rd[1], h_rd[2], h_rd[3], h_rd[4]}), 32'b11000);
    chk("d2_occ_full", 32'(h_occ[4]), 32'd2);
    chk("d2_hold_data", 32'({h_data[1], h_data[2], h_data[3], h_data[4]}), 32'hA0A0A0A0);
    chk("d2_streaming", 32'({h_xfer[5], h_xfer[6], h_xfer[7], h_xfer[8],
                             h_xfer[9], h_xfer[10], h_xfer[11], h_xfer[12]}), 32'hFF);
    chk("d2_idle_after", 32'(h_valid[13]), 32'd0);
    chk("d2_all_out", 32'(exp_q.size()), 32'd0);

    // Directed 3: burst tagging over ten words from a clean reset.
    apply_reset();
    start_test();
    for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1);
    chk("d3_last_positions", lastmask, 32'h0000_0110);
    chk("d3_beat_cnt", 32'(dut.beat_cnt), 32'd2);
    chk("d3_xfer_count", 32'(xfer_count), 32'd10);

    // Directed 4: enable dropped the cycle after a read is issued.
    start_test();
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1);
    chk("d4_first_rd", 32'(h_rd[0]), 32'd1);
    chk("d4_no_rd_disabled", 32'({h_rd[1], h_rd[2], h_rd[3], h_rd[4]}), 32'd0);
    chk("d4_inflight_out", 32'({h_xfer[1], h_data[1]}), 32'h150);
    chk("d4_quiet", 32'({h_valid[2], h_valid[3], h_valid[4]}), 32'd0);
    chk("d4_last_positions", lastmask, 32'h0000_0004);
    chk("d4_beat_cnt", 32'(dut.beat_cnt), 32'd3);
    chk("d4_xfer_count", 32'(xfer_count), 32'd15);

    // Directed 5: reset with a word in flight and a word buffered.
    start_test();
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("d5_pre_occ", 32'(dut.occ), 32'd1);
    chk("d5_pre_inflight", 32'(dut.inflight), 32'd1);
    apply_reset();
    start_test();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("d5_nothing_after", 32'({h_valid[0], h_valid[1]}), 32'd0);
    chk("d5_remaining", 32'(exp_q.size()), 32'd2);

    // Random: bursty FIFO fill, 50% ready, mostly enabled.
    start_test();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4) push(8'($urandom_range(0, 255)));
      en_r  = ($urandom_range(0, 9) != 0);
      rdy_r = 1'($urandom_range(0, 1));
      cyc(en_r, rdy_r);
    end
    guard = 0;
    while (!(exp_q.size() == 0 && fifo_empty && outst == 0) && guard < 300) begin
      cyc(1'b1, 1'b1);
      guard++;
    end
    chk("rand_drained", 32'(exp_q.size() == 0 && fifo_empty && outst == 0), 32'd1);
    chk("rand_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, fails);
    $finish;
  end

endmodule
